// File: rtl/conv_encoder_k4_pkg.sv
// ============================================================================
// Module   : conv_encoder_k4_pkg
// Purpose  : Shared trellis constants and types for the K=4 rate-1/2 encoder
//            and the matching Viterbi decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_encoder_k4_pkg;

    localparam int          K       = 4;
    localparam int          STATE_W = K - 1;
    localparam logic [K-1:0] G0     = 4'b1111;
    localparam logic [K-1:0] G1     = 4'b1101;
    localparam int          TAIL_W  = $clog2(K - 1);

    typedef logic [STATE_W-1:0] trellis_state_t;
    typedef logic [1:0]         code_pair_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TAIL = 1'b1
    } enc_fsm_t;

endpackage

`default_nettype wire

// File: rtl/conv_encoder_k4_core.sv
// ============================================================================
// Module   : conv_enc_core
// Purpose  : Combinational trellis step (state, d) -> (code pair, next state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_enc_core
    import conv_encoder_k4_pkg::*;
(
    input  trellis_state_t state,
    input  logic           d,
    output code_pair_t     pair,
    output trellis_state_t next_state
);

    // Register image: current bit in the MSB, oldest past bit in the LSB.
    logic [K-1:0] r;

    assign r          = {d, state};
    assign pair       = {^(r & G0), ^(r & G1)};
    assign next_state = {d, state[STATE_W-1:1]};

endmodule

`default_nettype wire

// File: rtl/conv_encoder_k4.sv
// ============================================================================
// Module   : conv_encoder_k4
// Purpose  : Framed rate-1/2 K=4 convolutional encoder with zero-tail flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder_k4
    import conv_encoder_k4_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_pair,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(K - 2);

    enc_fsm_t          fsm_q,       fsm_d;
    trellis_state_t    state_q,     state_d;
    logic [TAIL_W-1:0] tail_cnt_q,  tail_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    code_pair_t        out_pair_q,  out_pair_d;

    logic              slot_free;
    logic              load_data;
    logic              load_tail;
    logic              tail_done;
    logic              core_d;
    code_pair_t        core_pair;
    trellis_state_t    core_next;

    assign slot_free = !out_valid_q | out_ready;
    assign in_ready  = (fsm_q == RUN) & slot_free & rst_n;
    assign load_data = in_valid & in_ready;
    assign load_tail = (fsm_q == TAIL) & slot_free;
    assign tail_done = load_tail & (tail_cnt_q == TAIL_LAST);

    // Tail beats feed zeros so the trellis drains back to state 000.
    assign core_d = (fsm_q == RUN) ? in_bit : 1'b0;

    conv_enc_core u_core (
        .state      (state_q),
        .d          (core_d),
        .pair       (core_pair),
        .next_state (core_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= RUN;
            state_q     <= '0;
            tail_cnt_q  <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pair_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            tail_cnt_q  <= tail_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_pair_q  <= out_pair_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            RUN:     if (load_data && in_last) fsm_d = TAIL;
            TAIL:    if (tail_done)            fsm_d = RUN;
            default:                           fsm_d = RUN;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tail_cnt_d  = tail_cnt_q;
        frame_cnt_d = frame_cnt_q + CNT_W'(tail_done);
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_pair_d  = out_pair_q;

        if (load_data || load_tail) begin
            state_d     = core_next;
            out_pair_d  = core_pair;
            out_valid_d = 1'b1;
            out_last_d  = tail_done;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (load_data && in_last) begin
            tail_cnt_d = '0;
        end else if (load_tail) begin
            tail_cnt_d = tail_cnt_q + TAIL_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;
    assign busy      = (fsm_q == TAIL);
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_k4.sv
// ============================================================================
// Module   : tb_conv_encoder_k4
// Purpose  : Directed self-checking bench for conv_encoder_k4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder_k4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_pair;
    logic        out_last;
    logic        busy;
    logic [15:0] frame_cnt;

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          nrdy_lo = 0;
    int          n_last  = 0;
    logic [1:0]  got_p[$];
    logic        got_l[$];
    int          got_c[$];

    conv_encoder_k4 #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records handshakes, counts in_ready-low cycles, and checks held outputs across stalls.
    task automatic tick();
        bit         stall;
        logic [2:0] hold;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_p.push_back(out_pair);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
            if (out_last === 1'b1) n_last++;
        end
        if (in_ready !== 1'b1) nrdy_lo++;
        stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        hold  = {out_last, out_pair};
        @(posedge clk);
        #1;
        cyc++;
        if (stall && rst_n)
            check("stall_hold", 32'({out_valid, out_last, out_pair}), 32'({1'b1, hold}));
    endtask

    task automatic clear();
        got_p.delete();
        got_l.delete();
        got_c.delete();
        n_last = 0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int len, input bit rnd);
        for (int i = 0; i < len; i++) begin
            bit acc;
            int guard;
            acc      = 1'b0;
            guard    = 0;
            in_valid = 1'b1;
            in_bit   = bits[len-1-i];
            in_last  = (i == len - 1);
            while (!acc && guard < 200) begin
                if (rnd) out_ready = 1'($urandom_range(0, 1));
                #1;
                acc = (in_ready === 1'b1);
                tick();
                guard++;
            end
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int target, input bit rnd);
        int guard;
        guard = 0;
        while (n_last < target && guard < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
            tick();
            guard++;
        end
        if (n_last < target) check("drain_timeout", 32'(n_last), 32'(target));
        out_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input logic [31:0] ep, input logic [15:0] el, input int n);
        check({tag, "_count"}, 32'(got_p.size()), 32'(n));
        for (int i = 0; i < n && i < got_p.size(); i++) begin
            check($sformatf("%s_pair%0d", tag, i), 32'(got_p[i]), 32'(ep[2*(n-1-i) +: 2]));
            check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(el[n-1-i]));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_pair",  32'(out_pair),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: single-bit frame
        clear();
        send_bits(8'b1, 1, 1'b0);
        drain(1, 1'b0);
        check_seq("t1", 32'b11111011, 16'b0001, 4);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_state", 32'(dut.state_q), 32'd0);

        // Test 2: frame 1011
        clear();
        send_bits(8'b1011, 4, 1'b0);
        drain(1, 1'b0);
        check_seq("t2", 32'b11110111010111, 16'b0000001, 7);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
        check("t2_state", 32'(dut.state_q), 32'd0);

        // Test 3: frame 1011 with random backpressure
        clear();
        send_bits(8'b1011, 4, 1'b1);
        drain(1, 1'b1);
        check_seq("t3", 32'b11110111010111, 16'b0000001, 7);
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Test 4: two frames back to back
        clear();
        send_bits(8'b1011, 4, 1'b0);
        nrdy_lo = 0;
        send_bits(8'b1011, 4, 1'b0);
        check("t4_ready_gap", 32'(nrdy_lo), 32'd3);
        drain(2, 1'b0);
        check_seq("t4", 32'b1111011101011111110111010111, 16'b00000010000001, 14);
        if (got_c.size() == 14)
            check("t4_consecutive", 32'(got_c[13] - got_c[0]), 32'd13);
        else
            check("t4_consecutive_size", 32'(got_c.size()), 32'd14);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

        // Test 5: reset during the second tail beat
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        send_bits(8'b1011, 4, 1'b0);
        tick();
        tick();
        check("t5_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_out_valid",  32'(out_valid), 32'd0);
        check("t5_out_last",   32'(out_last),  32'd0);
        check("t5_in_ready",   32'(in_ready),  32'd0);
        check("t5_busy",       32'(busy),      32'd0);
        check("t5_frame_cnt",  32'(frame_cnt), 32'd0);
        check("t5_no_last",    32'(n_last),    32'd0);
        check_seq("t5_partial", 32'b1111011101, 16'b0, 5);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t5_state", 32'(dut.state_q), 32'd0);
        check("t5_run",   32'(in_ready),    32'd1);
        clear();
        send_bits(8'b1, 1, 1'b0);
        drain(1, 1'b0);
        check_seq("t5_after", 32'b11111011, 16'b0001, 4);
        check("t5_after_cnt", 32'(frame_cnt), 32'd1);

        // Test 6: frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        #1;
        check("t6_forced", 32'(frame_cnt), 32'hFFFF);
        clear();
        send_bits(8'b1, 1, 1'b0);
        drain(1, 1'b0);
        check_seq("t6", 32'b11111011, 16'b0001, 4);
        check("t6_wrap", 32'(frame_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
